// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: command, write-data, read-data and memory-port signals of the burst sequencer.
// Latency: none (wires only).
// Backpressure: cmd and wdata use valid/ready; the memory port answers each request with mem_ready_i.
interface mem_burst_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_wr_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [LEN_WIDTH-1:0]  cmd_len_i;
    logic                  wdata_valid_i;
    logic                  wdata_ready_o;
    logic [WIDTH-1:0]      wdata_i;
    logic                  rdata_valid_o;
    logic [WIDTH-1:0]      rdata_o;
    logic                  done_o;
    logic                  error_o;
    logic                  mem_valid_o;
    logic                  mem_wr_rd_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0]      mem_wdata_o;
    logic [WIDTH-1:0]      mem_rdata_i;
    logic                  mem_ready_i;

    // Controller side.
    modport master (
        input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        input  wdata_valid_i, wdata_i, mem_rdata_i, mem_ready_i,
        output cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o, error_o,
        output mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o
    );

    // Environment side: command source, write-data source, read-data sink and memory.
    modport slave (
        output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        output wdata_valid_i, wdata_i, mem_rdata_i, mem_ready_i,
        input  cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o, error_o,
        input  mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: splits one 1..16 word read/write burst into single-word memory requests.
// Latency: 3 cycles per word (ISSUE, WAIT1, WAIT2) against a zero-wait memory; done_o with the last word.
// Backpressure: stalls in ISSUE without write data, in WAIT2 until mem_ready_i; MEM_BURST_TIMEOUT_EN bounds WAIT2.
module mem_burst_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_burst_ctrl_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT1 = 2'd2;
    localparam logic [1:0] S_WAIT2 = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  cmd_hs;

`ifdef MEM_BURST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             error_q, error_d;
`endif

    // cmd_ready is registered so it rises one cycle after reset release and one cycle after done_o.
    assign cmd_hs   = bus.cmd_valid_i && cmd_ready_q;
    // Explicit wrap keeps non-power-of-2 depths inside the memory.
    assign addr_nxt = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

    // Burst sequencing: next state, request registers and per-word bookkeeping.
    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        cmd_ready_d   = 1'b0;
        mem_valid_d   = 1'b0;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
`ifdef MEM_BURST_TIMEOUT_EN
        tmo_cnt_d     = '0;
        error_d       = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_hs) begin
                    wr_d        = bus.cmd_wr_i;
                    addr_d      = bus.cmd_addr_i;
                    remaining_d = bus.cmd_len_i;
                    cmd_ready_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Reads issue at once; writes wait for a word from upstream.
                if (!wr_q || bus.wdata_valid_i) begin
                    mem_valid_d = 1'b1;
                    mem_wr_d    = wr_q;
                    mem_addr_d  = addr_q;
                    if (wr_q) begin
                        mem_wdata_d = bus.wdata_i;
                    end
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                // mem_ready_i here predates the memory sampling our request, so it is ignored.
                state_d = S_WAIT2;
            end
            default: begin
                if (bus.mem_ready_i) begin
                    if (!wr_q) begin
                        rdata_d       = bus.mem_rdata_i;
                        rdata_valid_d = 1'b1;
                    end
                    addr_d = addr_nxt;
                    if (remaining_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
`ifdef MEM_BURST_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // Give up on the memory: flag it and drop the rest of the burst.
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
        endcase
    end

    // State and output registers; reset aborts any burst and clears the memory request at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            cmd_ready_q   <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef MEM_BURST_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            cmd_ready_q   <= cmd_ready_d;
            mem_valid_q   <= mem_valid_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
`ifdef MEM_BURST_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            error_q       <= error_d;
`endif
        end
    end

    assign bus.cmd_ready_o    = cmd_ready_q;
    assign bus.wdata_ready_o  = (state_q == S_ISSUE) && wr_q;
    assign bus.rdata_valid_o  = rdata_valid_q;
    assign bus.rdata_o        = rdata_q;
    assign bus.done_o         = done_q;
    assign bus.mem_valid_o    = mem_valid_q;
    assign bus.mem_wr_rd_en_o = mem_wr_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_wdata_o    = mem_wdata_q;
`ifdef MEM_BURST_TIMEOUT_EN
    assign bus.error_o        = error_q;
`else
    assign bus.error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed and randomized bursts against a behavioural memory and reference image.
// Latency: memory answers mem_valid_o after a programmable 0..3 extra cycles.
// Backpressure: write data gaps and memory latency are randomized per burst.
module tb_mem_burst_ctrl;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int LW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_burst_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    mem_burst_ctrl #(
        .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(15)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int stall_viol = 0;
    int mem_lat = 0;
    bit mem_mute = 1'b0;
    logic           mem_busy;
    int             mem_cnt;
    logic [W-1:0]   mem_arr [D] = '{default: '0};
    logic [W-1:0]   ref_mem [D] = '{default: '0};
    logic [W-1:0]   wbuf    [16];
    logic [W-1:0]   rd_dat_q[$];
    int             rd_edge_q[$];
    int             done_n = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] outs_vec();
        return {bus.cmd_ready_o, bus.wdata_ready_o, bus.rdata_valid_o, bus.rdata_o, bus.done_o,
                bus.error_o, bus.mem_valid_o, bus.mem_wr_rd_en_o, bus.mem_addr_o, bus.mem_wdata_o};
    endfunction

    // Edge counter: at a negedge it holds the index of the posedge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory: samples a request, answers mem_lat cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ready_i <= 1'b0;
            bus.mem_rdata_i <= '0;
            mem_busy        <= 1'b0;
            mem_cnt         <= 0;
        end else begin
            bus.mem_ready_i <= 1'b0;
            if (bus.mem_valid_o) begin
                if (bus.mem_wr_rd_en_o) mem_arr[bus.mem_addr_o] <= bus.mem_wdata_o;
                else                    bus.mem_rdata_i <= mem_arr[bus.mem_addr_o];
                if (mem_lat == 0) bus.mem_ready_i <= !mem_mute;
                else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= mem_lat;
                end
            end else if (mem_busy) begin
                if (mem_cnt == 1) begin
                    bus.mem_ready_i <= !mem_mute;
                    mem_busy        <= 1'b0;
                end
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.rdata_valid_o) begin
            rd_dat_q.push_back(bus.rdata_o);
            rd_edge_q.push_back(cyc);
        end
        if (bus.done_o) done_n++;
    end

    task automatic clear_rd();
        rd_dat_q.delete();
        rd_edge_q.delete();
    endtask

    // Reference image update for a completed write burst.
    task automatic ref_write(input int addr, input int len);
        for (int i = 0; i <= len; i++) ref_mem[(addr + i) % D] = wbuf[i];
    endtask

    // Runs one burst; returns the handshake edge and the done edge.
    task automatic do_burst(input bit wr, input int addr, input int len, input int gap_word,
                            input int gap_len, output int hs_edge, output int end_edge, output bit ok);
        int widx = 0;
        int gap_cnt = 0;
        bit hs_c, hs_w;
        bit accepted = 1'b0;
        ok = 1'b0;
        hs_edge = -1;
        end_edge = -1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_wr_i    = wr;
        bus.cmd_addr_i  = AW'(addr);
        bus.cmd_len_i   = LW'(len);
        for (int t = 0; t < 400; t++) begin
            bus.wdata_valid_i = wr && (widx <= len) && !(widx == gap_word && gap_cnt < gap_len);
            bus.wdata_i       = wbuf[widx % 16];
            #1;
            hs_c = bus.cmd_valid_i && bus.cmd_ready_o;
            hs_w = bus.wdata_valid_i && bus.wdata_ready_o;
            if (wr && bus.wdata_ready_o && widx == gap_word && gap_cnt < gap_len) begin
                gap_cnt++;
                if (bus.mem_valid_o) stall_viol++;
            end
            @(negedge clk);
            if (hs_c) begin
                bus.cmd_valid_i = 1'b0;
                accepted = 1'b1;
                hs_edge = cyc;
            end
            if (hs_w) widx++;
            if (accepted && bus.done_o) begin
                end_edge = cyc;
                ok = 1'b1;
                break;
            end
        end
        bus.cmd_valid_i   = 1'b0;
        bus.wdata_valid_i = 1'b0;
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit=2000000ns");
        $fatal(1);
    end

    initial begin
        int hs, de, hs1, hs2, d1, base, busy_rdy, exp_cyc, gw, gl;
        bit ok, wr, seen, found, hs_c;
        int addr, len;
        logic [W-1:0] old7, old8, old9;

        bus.cmd_valid_i   = 1'b0;
        bus.cmd_wr_i      = 1'b0;
        bus.cmd_addr_i    = '0;
        bus.cmd_len_i     = '0;
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i       = '0;

        // Reset values and cmd_ready rising one cycle after release.
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", 32'(outs_vec()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rdy_before_edge", 32'(bus.cmd_ready_o), 32'h0);
        @(posedge clk);
        #1;
        check_val("rdy_after_release", 32'(bus.cmd_ready_o), 32'h1);

        // Write burst wrapping the top of memory.
        for (int i = 0; i < 4; i++) wbuf[i] = W'(8'hA0 + i);
        do_burst(1'b1, 14, 3, -1, 0, hs, de, ok);
        check_val("wr_done_seen", 32'(ok), 32'h1);
        check_val("wr_done_latency", 32'(de - hs), 32'd12);
        ref_write(14, 3);
        check_val("wr_mem14", 32'(mem_arr[14]), 32'hA0);
        check_val("wr_mem15", 32'(mem_arr[15]), 32'hA1);
        check_val("wr_mem0",  32'(mem_arr[0]),  32'hA2);
        check_val("wr_mem1",  32'(mem_arr[1]),  32'hA3);

        // Read-back: data and 3k+3 pulse timing, done on the last pulse.
        clear_rd();
        do_burst(1'b0, 14, 3, -1, 0, hs, de, ok);
        check_val("rd_done_seen", 32'(ok), 32'h1);
        check_val("rd_count", 32'(rd_dat_q.size()), 32'd4);
        if (rd_dat_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check_val("rd_data", 32'(rd_dat_q[k]), 32'hA0 + 32'(k));
                check_val("rd_timing", 32'(rd_edge_q[k] - hs), 32'(3 * k + 3));
            end
            check_val("rd_done_with_last", 32'(de), 32'(rd_edge_q[3]));
        end

        // Write stall of 5 ISSUE cycles before word 2.
        for (int i = 0; i < 4; i++) wbuf[i] = W'(8'h50 + i);
        stall_viol = 0;
        do_burst(1'b1, 2, 3, 2, 5, hs, de, ok);
        check_val("stall_done_seen", 32'(ok), 32'h1);
        check_val("stall_latency", 32'(de - hs), 32'd17);
        check_val("stall_no_mem_valid", 32'(stall_viol), 32'd0);
        ref_write(2, 3);
        for (int i = 0; i < 4; i++) check_val("stall_mem", 32'(mem_arr[2 + i]), 32'h50 + 32'(i));

        // Command held valid during a burst is ignored until after done_o.
        clear_rd();
        base = done_n;
        hs1 = -1; hs2 = -1; d1 = -1; busy_rdy = 0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_wr_i    = 1'b0;
        bus.cmd_addr_i  = 4'd3;
        bus.cmd_len_i   = 4'd1;
        for (int t = 0; t < 100; t++) begin
            #1;
            hs_c = bus.cmd_valid_i && bus.cmd_ready_o;
            @(negedge clk);
            if (hs_c) begin
                if (hs1 < 0) begin
                    hs1 = cyc;
                    bus.cmd_addr_i = 4'd9;
                    bus.cmd_len_i  = 4'd0;
                end else begin
                    hs2 = cyc;
                    bus.cmd_valid_i = 1'b0;
                    break;
                end
            end
            if (hs1 >= 0 && d1 < 0 && bus.cmd_ready_o) busy_rdy++;
            if (hs1 >= 0 && d1 < 0 && bus.done_o) d1 = cyc;
        end
        bus.cmd_valid_i = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #2;
            if (done_n - base >= 2) break;
        end
        check_val("busy_rdy_low", 32'(busy_rdy), 32'd0);
        check_val("busy_accept_after_done", 32'(hs2 - d1), 32'd2);
        check_val("busy_done_count", 32'(done_n - base), 32'd2);
        check_val("busy_rd_count", 32'(rd_dat_q.size()), 32'd3);
        if (rd_dat_q.size() == 3) begin
            check_val("busy_rd0", 32'(rd_dat_q[0]), 32'(ref_mem[3]));
            check_val("busy_rd1", 32'(rd_dat_q[1]), 32'(ref_mem[4]));
            check_val("busy_rd2", 32'(rd_dat_q[2]), 32'(ref_mem[9]));
        end

        // Reset during WAIT2 of the first word of a 4-word write.
        base = done_n;
        old7 = ref_mem[7]; old8 = ref_mem[8]; old9 = ref_mem[9];
        seen = 1'b0; found = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i   = 1'b1;
        bus.cmd_wr_i      = 1'b1;
        bus.cmd_addr_i    = 4'd6;
        bus.cmd_len_i     = 4'd3;
        bus.wdata_valid_i = 1'b1;
        bus.wdata_i       = 8'hC0;
        for (int t = 0; t < 40; t++) begin
            #1;
            hs_c = bus.cmd_valid_i && bus.cmd_ready_o;
            @(negedge clk);
            if (hs_c) bus.cmd_valid_i = 1'b0;
            if (seen) begin
                found = 1'b1;
                break;
            end
            if (bus.mem_valid_o) seen = 1'b1;
        end
        check_val("rst_reached_wait2", 32'(found), 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outputs", 32'(outs_vec()), 32'h0);
        bus.cmd_valid_i   = 1'b0;
        bus.wdata_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ref_mem[6] = 8'hC0;
        check_val("rst_mem6", 32'(mem_arr[6]), 32'hC0);
        check_val("rst_mem7", 32'(mem_arr[7]), 32'(old7));
        check_val("rst_mem8", 32'(mem_arr[8]), 32'(old8));
        check_val("rst_mem9", 32'(mem_arr[9]), 32'(old9));
        check_val("rst_no_done", 32'(done_n - base), 32'd0);
        check_val("rst_rdy_back", 32'(bus.cmd_ready_o), 32'h1);

`ifdef MEM_BURST_TIMEOUT_EN
        // Memory never answers: timeout after 15 WAIT2 cycles, no read data.
        clear_rd();
        mem_mute = 1'b1;
        mem_lat  = 0;
        do_burst(1'b0, 5, 0, -1, 0, hs, de, ok);
        check_val("tmo_done_seen", 32'(ok), 32'h1);
        check_val("tmo_latency", 32'(de - hs), 32'd17);
        check_val("tmo_error", 32'(bus.error_o), 32'h1);
        check_val("tmo_no_rdata", 32'(rd_dat_q.size()), 32'd0);
        mem_mute = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
`endif

        // Randomized bursts with memory latency and write-data gaps.
        for (int n = 0; n < 24; n++) begin
            wr      = 1'($urandom_range(0, 1));
            addr    = int'($urandom_range(0, D - 1));
            len     = int'($urandom_range(0, 15));
            mem_lat = int'($urandom_range(0, 3));
            gw      = wr ? int'($urandom_range(0, 15)) : -1;
            gl      = wr ? int'($urandom_range(0, 4)) : 0;
            for (int i = 0; i < 16; i++) wbuf[i] = W'($urandom);
            clear_rd();
            do_burst(wr, addr, len, gw, gl, hs, de, ok);
            check_val("rnd_done_seen", 32'(ok), 32'h1);
            exp_cyc = (3 + mem_lat) * (len + 1) + ((gw >= 0 && gw <= len) ? gl : 0);
            check_val("rnd_latency", 32'(de - hs), 32'(exp_cyc));
            if (wr) begin
                ref_write(addr, len);
                check_val("rnd_wr_no_rdata", 32'(rd_dat_q.size()), 32'd0);
            end else begin
                check_val("rnd_rd_count", 32'(rd_dat_q.size()), 32'(len + 1));
                if (rd_dat_q.size() == len + 1)
                    for (int k = 0; k <= len; k++)
                        check_val("rnd_rd_data", 32'(rd_dat_q[k]), 32'(ref_mem[(addr + k) % D]));
            end
        end
        mem_lat = 0;
        for (int i = 0; i < D; i++) check_val("final_mem", 32'(mem_arr[i]), 32'(ref_mem[i]));
`ifndef MEM_BURST_TIMEOUT_EN
        check_val("error_tied_low", 32'(bus.error_o), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
